// File: rtl/enc_pkg.sv
// Shared definitions for the 4-to-2 encoder: bus widths, index type and one-hot table.
package enc_pkg;

    localparam int unsigned ENC_IN_W  = 4;
    localparam int unsigned ENC_OUT_W = 2;

    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

    // Legal one-hot request codes, indexed by the position of the set bit
    localparam logic [ENC_IN_W-1:0] OH0 = 4'b0001;
    localparam logic [ENC_IN_W-1:0] OH1 = 4'b0010;
    localparam logic [ENC_IN_W-1:0] OH2 = 4'b0100;
    localparam logic [ENC_IN_W-1:0] OH3 = 4'b1000;

endpackage : enc_pkg

// File: rtl/enc4_core.sv
// Combinational 4-to-2 priority encoder core.
//   din       : request vector
//   idx_c     : index of the selected set bit (highest or lowest per PRIO_HIGH)
//   any_c     : at least one bit of din is set
//   multi_c   : two or more bits of din are set
module enc4_core
    import enc_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic [ENC_IN_W-1:0] din,
    output enc_idx_t            idx_c,
    output logic                any_c,
    output logic                multi_c
);

    // Index selection: the last match in scan order wins, so scan order sets priority
    always_comb begin
        idx_c = '0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < int'(ENC_IN_W); i++) begin
                if (din[i]) idx_c = enc_idx_t'(i);
            end
        end else begin
            for (int i = int'(ENC_IN_W) - 1; i >= 0; i--) begin
                if (din[i]) idx_c = enc_idx_t'(i);
            end
        end
    end

    // Anything non-zero that is not a legal one-hot code has two or more bits set
    always_comb begin
        any_c   = |din;
        multi_c = any_c && !(din inside {OH0, OH1, OH2, OH3});
    end

endmodule : enc4_core

// File: rtl/encoder_4to2.sv
// Registered 4-to-2 binary encoder with multi-hot detection and a saturating
// error counter. One cycle of latency, new din accepted every cycle.
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   din      : request vector, ideally one-hot
//   dout     : registered index of the selected set bit
//   valid    : registered, at least one din bit was set
//   err      : registered, more than one din bit was set
//   err_cnt  : number of cycles err was asserted, saturating at all-ones
module encoder_4to2
    import enc_pkg::*;
#(
    parameter bit          PRIO_HIGH = 1'b1,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ENC_IN_W-1:0]  din,
    output logic [ENC_OUT_W-1:0] dout,
    output logic                 valid,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    enc_idx_t             idx_c;
    logic                 any_c;
    logic                 multi_c;

    enc_idx_t             dout_q;
    logic                 valid_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    enc4_core #(
        .PRIO_HIGH (PRIO_HIGH)
    ) u_core (
        .din     (din),
        .idx_c   (idx_c),
        .any_c   (any_c),
        .multi_c (multi_c)
    );

    // Counter advances on the same edge that registers err=1, and holds at all-ones
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (multi_c && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Output and counter registers; reset discards whatever din was presented
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            dout_q    <= idx_c;
            valid_q   <= any_c;
            err_q     <= multi_c;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule : encoder_4to2

// File: tb/tb_encoder_4to2.sv
// Scoreboard bench for encoder_4to2: three instances (default, low priority,
// 2-bit counter) share rst/din; expectations are queued at drive time and
// popped by a monitor after each rising edge.
module tb_encoder_4to2;

    typedef struct {
        logic [1:0]  dout;
        logic        valid;
        logic        err;
        int unsigned cnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] din;

    logic [1:0] dout_a, dout_b, dout_c;
    logic       valid_a, valid_b, valid_c;
    logic       err_a, err_b, err_c;
    logic [7:0] cnt_a_o, cnt_b_o;
    logic [1:0] cnt_c_o;

    exp_t        qa[$], qb[$], qc[$];
    int unsigned cnt_a, cnt_b, cnt_c;
    int          n_tests;
    int          n_fail;

    encoder_4to2 #(.PRIO_HIGH(1'b1), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .din(din),
        .dout(dout_a), .valid(valid_a), .err(err_a), .err_cnt(cnt_a_o));

    encoder_4to2 #(.PRIO_HIGH(1'b0), .ERR_CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .din(din),
        .dout(dout_b), .valid(valid_b), .err(err_b), .err_cnt(cnt_b_o));

    encoder_4to2 #(.PRIO_HIGH(1'b1), .ERR_CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .din(din),
        .dout(dout_c), .valid(valid_c), .err(err_c), .err_cnt(cnt_c_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index from arithmetic on din value, counter from a saturating add
    function automatic exp_t model(input bit r, input logic [3:0] d, input bit prio,
                                   input int unsigned prev, input int unsigned maxc);
        exp_t e;
        int   v;
        int   pop;
        v   = int'(d);
        pop = $countones(d);
        e.dout  = 2'b00;
        e.valid = 1'b0;
        e.err   = 1'b0;
        e.cnt   = prev;
        if (r) begin
            e.cnt = 0;
        end else begin
            if (v != 0) begin
                if (prio) e.dout = 2'($clog2(v + 1) - 1);
                else      e.dout = 2'($clog2(v & (-v)));
            end
            e.valid = (pop >= 1);
            e.err   = (pop >= 2);
            if (e.err && prev < maxc) e.cnt = prev + 1;
        end
        return e;
    endfunction

    task automatic step(input bit r, input logic [3:0] d);
        rst = r;
        din = d;
        qa.push_back(model(r, d, 1'b1, cnt_a, 255)); cnt_a = qa[$].cnt;
        qb.push_back(model(r, d, 1'b0, cnt_b, 255)); cnt_b = qb[$].cnt;
        qc.push_back(model(r, d, 1'b1, cnt_c, 3));   cnt_c = qc[$].cnt;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string nm, input exp_t e, input logic [1:0] d,
                         input logic v, input logic er, input int unsigned c);
        n_tests += 4;
        if (d !== e.dout) begin
            n_fail++;
            $display("FAIL %s dout: got %b expected %b", nm, d, e.dout);
        end
        if (v !== e.valid) begin
            n_fail++;
            $display("FAIL %s valid: got %b expected %b", nm, v, e.valid);
        end
        if (er !== e.err) begin
            n_fail++;
            $display("FAIL %s err: got %b expected %b", nm, er, e.err);
        end
        if (c != e.cnt) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d expected %0d", nm, c, e.cnt);
        end
    endtask

    // Monitor: every edge presents a new output; compare it against the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("A", e, dout_a, valid_a, err_a, int'(cnt_a_o));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("B", e, dout_b, valid_b, err_b, int'(cnt_b_o));
        end
        if (qc.size() > 0) begin
            e = qc.pop_front();
            check("C", e, dout_c, valid_c, err_c, int'(cnt_c_o));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh [4];
        n_tests = 0;
        n_fail  = 0;
        cnt_a   = 0;
        cnt_b   = 0;
        cnt_c   = 0;
        rst     = 1'b1;
        din     = 4'b0000;
        oh[0] = 4'b0001; oh[1] = 4'b0010; oh[2] = 4'b0100; oh[3] = 4'b1000;

        // Reset held two edges with multi-hot din present
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        // One-hot sweep
        for (int i = 0; i < 4; i++) step(1'b0, oh[i]);
        // Multi-hot pair, then idle
        step(1'b0, 4'b0110);
        step(1'b0, 4'b1111);
        step(1'b0, 4'b0000);
        // Saturation on the 2-bit counter instance
        step(1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0011);
        // Reset in the middle of a stream of 1000
        step(1'b0, 4'b1000);
        step(1'b0, 4'b1000);
        step(1'b1, 4'b1000);
        step(1'b0, 4'b1000);
        step(1'b0, 4'b1000);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)));
        end
        step(1'b0, 4'b0000);

        n_tests++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0",
                     qa.size() + qb.size() + qc.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_encoder_4to2
